// File: rtl/fact_pkg.sv
// Shared types and defaults for the round-robin factorial engine.
package fact_pkg;

    localparam int N_W_DEF = 4;
    localparam int Y_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot pick between two requesters; ptr names the requester favoured on a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] g;
        g = '0;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fact_arb_if.sv
// Requester-side bundle of the factorial arbiter: requests, operands, grant and result.
interface fact_arb_if
    import fact_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int Y_W = Y_W_DEF
);
    logic [1:0]     req;
    logic [N_W-1:0] n0;
    logic [N_W-1:0] n1;
    logic [1:0]     gnt;
    logic           busy;
    logic [1:0]     done;
    logic [Y_W-1:0] y;
    logic           ovf;

    modport master (
        output req, n0, n1,
        input  gnt, busy, done, y, ovf
    );

    modport slave (
        input  req, n0, n1,
        output gnt, busy, done, y, ovf
    );
endinterface

// File: rtl/fact_mul_sat.sv
// Combinational Y_W x N_W multiply, saturating to all-ones with an overflow flag.
module fact_mul_sat #(
    parameter int N_W = 4,
    parameter int Y_W = 16
) (
    input  logic [Y_W-1:0] a,
    input  logic [N_W-1:0] b,
    output logic [Y_W-1:0] p,
    output logic           ovf
);
    logic [Y_W+N_W-1:0] full;

    always_comb begin
        full = {{N_W{1'b0}}, a} * {{Y_W{1'b0}}, b};
        ovf  = |full[Y_W+N_W-1:Y_W];
        p    = ovf ? '1 : full[Y_W-1:0];
    end
endmodule

// File: rtl/fact_arb.sv
// Two-requester round-robin front end sharing one iterative saturating factorial engine.
module fact_arb
    import fact_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    fact_arb_if.slave  bus
);
    state_t         state;
    logic [1:0]     gnt_r;
    logic           ptr;
    logic [N_W-1:0] n_lat;
    logic [N_W-1:0] i;
    logic [Y_W-1:0] acc;
    logic           ovf_run;
    logic [Y_W-1:0] y_r;
    logic           ovf_r;

    logic [1:0]     pick;
    logic [N_W-1:0] sel_n;
    logic [Y_W-1:0] prod;
    logic           mul_ovf;

    fact_mul_sat #(
        .N_W (N_W),
        .Y_W (Y_W)
    ) u_mul (
        .a   (acc),
        .b   (i),
        .p   (prod),
        .ovf (mul_ovf)
    );

    always_comb begin
        pick  = rr_pick(bus.req, ptr);
        sel_n = pick[1] ? bus.n1 : bus.n0;
    end

    // y/ovf load on the edge entering DONE so they are valid alongside the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_r   <= '0;
            ptr     <= 1'b0;
            n_lat   <= '0;
            i       <= '0;
            acc     <= Y_W'(1);
            ovf_run <= 1'b0;
            y_r     <= '0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        gnt_r   <= pick;
                        n_lat   <= sel_n;
                        acc     <= Y_W'(1);
                        i       <= N_W'(1);
                        ovf_run <= 1'b0;
                        if (sel_n != '0) begin
                            state <= MUL;
                        end else begin
                            state <= DONE;
                            y_r   <= Y_W'(1);
                            ovf_r <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc     <= prod;
                    i       <= i + 1'b1;
                    ovf_run <= ovf_run | mul_ovf;
                    if (i == n_lat) begin
                        state <= DONE;
                        y_r   <= prod;
                        ovf_r <= ovf_run | mul_ovf;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt_r <= '0;
                    ptr   <= gnt_r[0];
                end
                default: begin
                    state <= IDLE;
                    gnt_r <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.gnt  = gnt_r;
        bus.busy = (state != IDLE);
        bus.done = (state == DONE) ? gnt_r : 2'b00;
        bus.y    = y_r;
        bus.ovf  = ovf_r;
    end
endmodule

// File: tb/tb_fact_arb.sv
// Directed bench for fact_arb: latency, saturation, round-robin and reset behaviour.
module tb_fact_arb;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fact_arb_if #(.N_W(4), .Y_W(16)) bus ();

    fact_arb #(.N_W(4), .Y_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gnt and done must stay at most one-hot on every sampled cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot_gnt", 32'($countones(bus.gnt) <= 1), 32'd1);
            chk("onehot_done", 32'($countones(bus.done) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] r, input logic [3:0] a,
                          input logic [3:0] b, input logic [1:0] exp_done,
                          input int exp_lat, input logic [15:0] exp_y, input logic exp_ovf);
        int lat;
        bus.req = r;
        bus.n0  = a;
        bus.n1  = b;
        @(negedge clk);
        lat = 1;
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_done));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (bus.done == 2'b00 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_done"}, 32'(bus.done), 32'(exp_done));
        chk({tag, "_y"}, 32'(bus.y), 32'(exp_y));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        bus.req = 2'b00;
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int  lat;
        logic bad;
        logic seen;
        vectors     = 0;
        miscompares = 0;
        bus.req     = 2'b00;
        bus.n0      = '0;
        bus.n1      = '0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("f5",  2'b01, 4'd5,  4'd0, 2'b01, 6,  16'd120,   1'b0);
        run_op("f0",  2'b10, 4'd0,  4'd0, 2'b10, 1,  16'd1,     1'b0);
        run_op("f1",  2'b10, 4'd0,  4'd1, 2'b10, 2,  16'd1,     1'b0);
        run_op("f8",  2'b01, 4'd8,  4'd0, 2'b01, 9,  16'd40320, 1'b0);
        run_op("f9",  2'b01, 4'd9,  4'd0, 2'b01, 10, 16'hFFFF,  1'b1);
        run_op("f15", 2'b01, 4'd15, 4'd0, 2'b01, 16, 16'hFFFF,  1'b1);
        run_op("f0b", 2'b01, 4'd0,  4'd0, 2'b01, 1,  16'd1,     1'b0);

        // Operand changed and request dropped while the operation runs.
        bus.req = 2'b01;
        bus.n0  = 4'd5;
        lat     = 0;
        bad     = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.done == 2'b00 && (bus.gnt != 2'b01 || bus.busy != 1'b1)) bad = 1'b1;
            if (lat == 2) bus.n0 = 4'd3;
            if (lat == 3) bus.req = 2'b00;
        end while (bus.done == 2'b00 && lat < 40);
        chk("chg_hold", 32'(bad), 32'd0);
        chk("chg_lat", 32'(lat), 32'd6);
        chk("chg_done", 32'(bus.done), 32'b01);
        chk("chg_gnt", 32'(bus.gnt), 32'b01);
        chk("chg_busy", 32'(bus.busy), 32'd1);
        chk("chg_y", 32'(bus.y), 32'd120);
        @(negedge clk);
        chk("chg_idle", 32'(bus.busy), 32'd0);

        // Tie after reset: requester 0 first, then requester 1 on the held tie.
        do_reset();
        bus.req = 2'b11;
        bus.n0  = 4'd3;
        bus.n1  = 4'd4;
        @(negedge clk);
        lat = 1;
        chk("rr_first_gnt", 32'(bus.gnt), 32'b01);
        while (bus.done == 2'b00 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rr_first_lat", 32'(lat), 32'd4);
        chk("rr_first_done", 32'(bus.done), 32'b01);
        chk("rr_first_y", 32'(bus.y), 32'd6);
        @(negedge clk);
        chk("rr_gap_gnt", 32'(bus.gnt), 32'd0);
        chk("rr_gap_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("rr_tie_gnt", 32'(bus.gnt), 32'b10);
        bus.req = 2'b10;
        lat = 1;
        while (bus.done == 2'b00 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rr_second_lat", 32'(lat), 32'd5);
        chk("rr_second_done", 32'(bus.done), 32'b10);
        chk("rr_second_y", 32'(bus.y), 32'd24);
        bus.req = 2'b00;
        @(negedge clk);

        // Asynchronous reset in the middle of a 7! computation.
        bus.req = 2'b01;
        bus.n0  = 4'd7;
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        bus.req = 2'b00;
        #1;
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_busy0", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_y", 32'(bus.y), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done != 2'b00) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op("f2", 2'b01, 4'd2, 4'd0, 2'b01, 3, 16'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fact_arb.md
FACT_ARB -- requirements
Module: fact_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter N_W, default 4, SHALL set the operand width.
REQ-003 Parameter Y_W, default 16, SHALL set the result width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  2  per-requester request, bit k = requester k, level-held until done[k].
REQ-007 n0  input  N_W  operand of requester 0.
REQ-008 n1  input  N_W  operand of requester 1.
REQ-009 gnt  output  2  one-hot owner of the shared engine; zero in IDLE.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  2  one-cycle pulse to the owning requester when its result is valid.
REQ-012 y  output  Y_W  result n!, saturated; held until the next acceptance.
REQ-013 ovf  output  1  high when the true n! exceeded 2^Y_W-1; qualified like y.

Function
REQ-014 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-015 IDLE with req==0 SHALL stay in IDLE.
REQ-016 IDLE with any req bit high SHALL accept one requester at the clock edge, latch its n, set gnt, load acc=1, i=1 and clear ovf.
REQ-017 On acceptance, the FSM SHALL go to MUL if the latched n>=1, else to DONE.
REQ-018 Arbitration SHALL be round-robin: on a tie, grant the requester not served last; the pointer resets to favour requester 0.
REQ-019 A single requester SHALL be granted regardless of the pointer.
REQ-020 Each MUL cycle SHALL perform acc <= sat(acc*i) and i <= i+1; MUL SHALL go to DONE after the edge where i==n.
REQ-021 The multiply SHALL be evaluated at Y_W+N_W bits.
REQ-022 If any nonzero bit lies above Y_W, the multiply SHALL saturate acc to all-ones and set ovf sticky for the operation; iteration SHALL continue so latency is fixed.
REQ-023 Latency: with acceptance at edge T, done[k] SHALL be high in the cycle after edge T+n (n=0: the cycle after T).
REQ-024 DONE SHALL last exactly one cycle: y=acc, done[gnt]=1, then go to IDLE, clear gnt and advance the RR pointer.
REQ-025 A change of n0/n1 after acceptance SHALL have no effect; the latched value is used.
REQ-026 req dropped mid-operation SHALL NOT abort; the operation SHALL complete and done SHALL still pulse.
REQ-027 A requester still requesting in the DONE cycle SHALL be treated as a new request in IDLE on the next cycle (IDLE costs one cycle between operations).
REQ-028 done SHALL never have both bits high; gnt SHALL never have both bits high.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, gnt=0, busy=0, done=0, y=0, ovf=0, acc=1 and RR pointer=requester 0, including mid-MUL.
REQ-030 After rst_n rises, the first acceptance SHALL occur no earlier than the first clock edge.
REQ-031 No done pulse SHALL be produced for an operation aborted by reset.

Structure
REQ-032 Package fact_pkg SHALL hold the state enum {IDLE,MUL,DONE} and the default N_W/Y_W constants.
REQ-033 Sub-module fact_mul_sat SHALL be a combinational Y_W x N_W multiply with saturation and overflow flag, instantiated once.
REQ-034 Arbitration, FSM and the acc/i registers SHALL live in fact_arb.

Verification
REQ-035 req=01, n0=5 alone: accept at T; done=01 in the cycle after T+5; y=120, ovf=0.
REQ-036 req=10, n1=0: done=10 in the cycle after T; y=1, ovf=0; n1=1 gives y=1 one cycle later.
REQ-037 n0=8 gives y=40320, ovf=0; n0=9 gives y=16'hFFFF, ovf=1; n0=15 gives y=16'hFFFF, ovf=1, done after T+15.
REQ-038 After reset, req=11, n0=3, n1=4: requester 0 is served first (y=6); requester 1 is accepted one cycle after done=01 (y=24); on the next tie, requester 1 wins.
REQ-039 rst_n pulsed low during MUL of n0=7: outputs are zero at once, no done pulse, and a new req=01 with n0=2 then gives y=2.
REQ-040 n0 changed 5->3 two cycles after acceptance: the result is still 120; gnt stays 01 throughout and busy=1 until DONE ends.
